// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: opcode field width, control opcodes,
// and the default-width fetch entry carried through the skid buffer.
package fetch_pkg;

    localparam int OP_W        = 4;
    localparam int DEF_INSTR_W = 24;
    localparam int DEF_ADDR_W  = 10;

    localparam logic [OP_W-1:0] OP_BR_A  = 4'b1100;
    localparam logic [OP_W-1:0] OP_BR_B  = 4'b1101;
    localparam logic [OP_W-1:0] OP_HALT  = 4'b1111;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetch entries with push, pop and flush. The entry type is
// a parameter so the top can match its own instruction and address widths.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  entry_t     push_data,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;

    // NOTE: non-blocking assignments for all clocked state so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every
    // read, so stale contents are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem reads, 2-entry skid buffer and
// valid/ready hand-off to decode. Define FETCH_HALT_EN to stop fetching on OP_HALT.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [OP_W-1:0]    if_op
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } slot_t;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              halted;
    logic [1:0]        count;
    logic [1:0]        occupancy;
    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;
    logic              flush;
    logic              halt_take;
    slot_t             arrive;
    slot_t             buf_head;
    slot_t             head;

    always_comb begin
        arrive.instr = imem_rdata;
        arrive.pc    = inflight_pc;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        head = '0;
        if (count != 2'd0)
            head = buf_head;
        else if (inflight)
            head = arrive;
    end

    assign if_valid = (count != 2'd0 || inflight) && !redirect_valid;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;
    assign if_op    = head.instr[INSTR_W-1 -: OP_W];
    assign accept   = if_valid && if_ready;

`ifdef FETCH_HALT_EN
    assign halt_take = accept && (if_op == OP_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halted <= 1'b0;
        else if (redirect_valid)
            halted <= 1'b0;
        else if (halt_take)
            halted <= 1'b1;
    end
`else
    assign halt_take = 1'b0;
    assign halted    = 1'b0;
`endif

    assign flush = redirect_valid || halt_take;

    // At most two words may be buffered or in flight, so the buffer can
    // always absorb the read issued this cycle.
    assign occupancy = count + {1'b0, inflight};
    assign issue     = rst_n && !redirect_valid && !halted && !halt_take
                       && (occupancy <= 2'd1);

    assign imem_en   = issue;
    assign imem_addr = pc;

    // Arriving data goes to the buffer unless it leaves straight to decode.
    assign pop  = accept && (count != 2'd0);
    assign push = inflight && !flush && !(accept && count == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            if (redirect_valid)
                pc <= redirect_pc;
            else if (issue)
                pc <= pc + ADDR_W'(1);
            inflight <= issue;
            if (issue)
                inflight_pc <= pc;
        end
    end

    fetch_skid_buffer #(
        .entry_t (slot_t)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .push_data (arrive),
        .head      (buf_head),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a 10-bit main instance driven through
// stall/redirect/halt/reset scenarios and a 4-bit instance checking PC wrap.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int ADDR_W   = 10;
    localparam int INSTR_W  = 24;
    localparam int NARROW_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic [3:0]         if_op;

    logic                n_imem_en;
    logic [NARROW_W-1:0] n_imem_addr;
    logic [INSTR_W-1:0]  n_imem_rdata;
    logic                n_redirect_valid;
    logic [NARROW_W-1:0] n_redirect_pc;
    logic                n_if_valid;
    logic                n_if_ready;
    logic [INSTR_W-1:0]  n_if_instr;
    logic [NARROW_W-1:0] n_if_pc;
    logic [3:0]          n_if_op;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC('0)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_op(if_op)
    );

    instr_fetch_unit #(.ADDR_W(NARROW_W), .INSTR_W(INSTR_W), .RESET_PC('0)) u_dut_narrow (
        .clk(clk), .rst_n(rst_n), .imem_en(n_imem_en), .imem_addr(n_imem_addr),
        .imem_rdata(n_imem_rdata), .redirect_valid(n_redirect_valid),
        .redirect_pc(n_redirect_pc), .if_valid(n_if_valid), .if_ready(n_if_ready),
        .if_instr(n_if_instr), .if_pc(n_if_pc), .if_op(n_if_op)
    );

    // ROM: word k holds k, except word 5 becomes a halt opcode when halt_word is set.
    logic halt_word;

    function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a, input logic hw);
        if (hw && a == ADDR_W'(5)) return {4'hF, 20'h00005};
        return INSTR_W'(a);
    endfunction

    always @(posedge clk) if (imem_en) imem_rdata <= rom_word(imem_addr, halt_word);
    always @(posedge clk) if (n_imem_en) n_imem_rdata <= INSTR_W'(n_imem_addr);

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_range(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) begin
            exp_t e;
            e.pc    = ADDR_W'(p);
            e.instr = rom_word(ADDR_W'(p), halt_word);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_delivery: got pc 0x%0h, expected none at %0t", if_pc, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc",    32'(if_pc),    32'(e.pc));
                check("sb_instr", 32'(if_instr), 32'(e.instr));
                check("sb_op",    32'(if_op),    32'(e.instr[INSTR_W-1 -: 4]));
            end
        end
    end

    // Narrow instance always ready: consecutive PCs wrapping 15 -> 0.
    logic [NARROW_W-1:0] n_exp_pc;
    always @(negedge clk) begin
        if (!rst_n)
            n_exp_pc = '0;
        else if (n_if_valid) begin
            check("narrow_pc",    32'(n_if_pc),    32'(n_exp_pc));
            check("narrow_instr", 32'(n_if_instr), 32'(n_exp_pc));
            n_exp_pc = n_exp_pc + 1'b1;
        end
    end

    int cyc;
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_en"},  32'(imem_en),  32'h0);
        check({tag, "_if_valid"}, 32'(if_valid), 32'h0);
        check({tag, "_if_instr"}, 32'(if_instr), 32'h0);
        check({tag, "_if_pc"},    32'(if_pc),    32'h0);
        check({tag, "_if_op"},    32'(if_op),    32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100us");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n            = 1'b0;
        if_ready         = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        n_if_ready       = 1'b1;
        n_redirect_valid = 1'b0;
        n_redirect_pc    = '0;
        halt_word        = 1'b0;
        cyc              = 0;

        repeat (3) @(posedge clk);
        sample();
        check_all_zero("reset");

        // Release before edge 0: cycle 0 fetches RESET_PC.
        #2 rst_n = 1'b1;
        push_range(0, 6);
        #1;
        check("c0_imem_en",   32'(imem_en),   32'h1);
        check("c0_imem_addr", 32'(imem_addr), 32'h0);
        check("c0_if_valid",  32'(if_valid),  32'h0);

        step(); sample();                                   // cycle 1
        check("c1_if_valid",  32'(if_valid),  32'h1);
        check("c1_if_pc",     32'(if_pc),     32'h0);
        check("c1_imem_addr", 32'(imem_addr), 32'h1);
        step(); sample();                                   // cycle 2
        check("c2_imem_addr", 32'(imem_addr), 32'h2);

        // Decode stalls in cycles 3..8; PC 2 held, fetch stops once two words are held.
        for (int c = 3; c <= 8; c++) begin
            step();
            if_ready = 1'b0;
            sample();
            check("stall_valid", 32'(if_valid), 32'h1);
            check("stall_pc",    32'(if_pc),    32'h2);
            if (cyc >= 5) check("stall_no_fetch", 32'(imem_en), 32'h0);
        end

        step(); if_ready = 1'b1; sample();                  // cycle 9
        check("rel_pc_9", 32'(if_pc), 32'h2);
        step(); sample();                                   // cycle 10
        check("rel_pc_10",     32'(if_pc),     32'h3);
        check("resume_en",     32'(imem_en),   32'h1);
        check("resume_addr",   32'(imem_addr), 32'h4);
        step(); sample();                                   // cycle 11
        check("rel_pc_11", 32'(if_pc), 32'h4);
        step(); step();                                     // cycles 12, 13

        // Fill the buffer (PC 7 held, PC 8 buffered), then redirect.
        step(); if_ready = 1'b0;                            // cycle 14
        step(); step(); sample();                           // cycle 16
        check("full_pc",      32'(if_pc),    32'h7);
        check("full_no_fetch", 32'(imem_en), 32'h0);

        step();                                             // cycle 17
        redirect_valid = 1'b1;
        redirect_pc    = ADDR_W'(10'h120);
        if_ready       = 1'b1;
        push_range(10'h120, 10'h122);
        sample();
        check("redir_valid_n",  32'(if_valid), 32'h0);
        check("redir_no_fetch", 32'(imem_en),  32'h0);
        step(); redirect_valid = 1'b0; sample();            // cycle 18
        check("redir1_valid", 32'(if_valid),  32'h0);
        check("redir1_en",    32'(imem_en),   32'h1);
        check("redir1_addr",  32'(imem_addr), 32'h120);
        step(); sample();                                   // cycle 19
        check("redir2_valid", 32'(if_valid), 32'h1);
        check("redir2_pc",    32'(if_pc),    32'h120);
        step(); step();                                     // cycles 20, 21

        // Redirect to 0 with a halt opcode planted at word 5.
        step();                                             // cycle 22
        redirect_valid = 1'b1;
        redirect_pc    = '0;
        halt_word      = 1'b1;
        push_range(0, 5);
`ifndef FETCH_HALT_EN
        push_range(6, 11);
`endif
        step(); redirect_valid = 1'b0;                      // cycle 23
        repeat (6) step();                                  // cycle 29
        sample();
        check("halt_word_pc", 32'(if_pc), 32'h5);
        check("halt_word_op", 32'(if_op), 32'hF);
        for (int c = 30; c <= 35; c++) begin
            step(); sample();
`ifdef FETCH_HALT_EN
            check("halted_valid", 32'(if_valid), 32'h0);
            check("halted_en",    32'(imem_en),  32'h0);
`else
            check("nohalt_pc", 32'(if_pc), 32'(c - 24));
`endif
        end

        step();                                             // cycle 36
        redirect_valid = 1'b1;
        redirect_pc    = ADDR_W'(10'h010);
        halt_word      = 1'b0;
        push_range(10'h010, 10'h011);
        sample();
        check("redir3_valid_n", 32'(if_valid), 32'h0);
        step(); redirect_valid = 1'b0; sample();            // cycle 37
        check("resume_halt_en",   32'(imem_en),   32'h1);
        check("resume_halt_addr", 32'(imem_addr), 32'h10);
        step(); sample();                                   // cycle 38
        check("resume_halt_pc", 32'(if_pc), 32'h10);
        step();                                             // cycle 39
        step(); if_ready = 1'b0;                            // cycle 40
        step(); step(); sample();                           // cycle 42
        check("prereset_valid", 32'(if_valid), 32'h1);
        check("prereset_pc",    32'(if_pc),    32'h12);
        check("prereset_en",    32'(imem_en),  32'h0);

        // Asynchronous reset in the middle of a full stall.
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        check("async_reset_addr", 32'(imem_addr), 32'h0);
        @(posedge clk);
        sample();
        #2 rst_n = 1'b1;
        if_ready = 1'b1;
        cyc = 0;
        push_range(0, 3);
        #1;
        check("restart_en",   32'(imem_en),   32'h1);
        check("restart_addr", 32'(imem_addr), 32'h0);
        step(); sample();
        check("restart_valid", 32'(if_valid), 32'h1);
        check("restart_pc",    32'(if_pc),    32'h0);
        step(); step(); step();                             // cycles 2..4
        step(); if_ready = 1'b0;                            // cycle 5
        step(); step(); sample();
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
